synapse_access_scheduler: RTL and testbench

Sequencing and arbitration controller in front of the synapse integer-weight BRAM (32 words × 4 byte lanes, 7-bit synapse index = word·4 + lane). It bulk-loads the weight table after reset, then shares the single BRAM port between spike-driven weight reads and STDP byte write-backs. STDP writes are buffered in a small FIFO, read-after-write hazards are resolved, and write starvation is bounded. Sits between the neuron/STDP logic and `syn_int_BRAM`.

---
 rtl/synapse_access_scheduler_if.sv | 62 ++++++
 rtl/synapse_access_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_synapse_access_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_access_scheduler_if.sv
// Bus bundle between the neuron/STDP logic, the access scheduler and the synapse weight BRAM.
// The scheduler connects through the slave modport; the requesting side uses master.
interface synapse_access_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8
);
  localparam int COL_BITS = $clog2(NUM_COL);
  localparam int SYN_BITS = ADDR_WIDTH + COL_BITS;
  localparam int WORD_W   = NUM_COL * COL_WIDTH;

  logic                  load_start;
  logic                  load_valid;
  logic [WORD_W-1:0]     load_data;
  logic                  load_ready;
  logic                  load_done;

  logic                  rd_req;
  logic [SYN_BITS-1:0]   rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [COL_WIDTH-1:0]  rd_data;

  logic                  wr_valid;
  logic [SYN_BITS-1:0]   wr_addr;
  logic [COL_WIDTH-1:0]  wr_data;
  logic                  wr_ready;

  logic                  bram_en;
  logic                  bram_wen;
  logic [NUM_COL-1:0]    bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [COL_BITS-1:0]   bram_col;
  logic [WORD_W-1:0]     bram_din;
  logic [COL_WIDTH-1:0]  bram_dout;

  logic                  busy;

  modport slave (
    input  load_start, load_valid, load_data,
    input  rd_req, rd_addr,
    input  wr_valid, wr_addr, wr_data,
    input  bram_dout,
    output load_ready, load_done,
    output rd_gnt, rd_valid, rd_data,
    output wr_ready,
    output bram_en, bram_wen, bram_we, bram_addr, bram_col, bram_din,
    output busy
  );

  modport master (
    output load_start, load_valid, load_data,
    output rd_req, rd_addr,
    output wr_valid, wr_addr, wr_data,
    output bram_dout,
    input  load_ready, load_done,
    input  rd_gnt, rd_valid, rd_data,
    input  wr_ready,
    input  bram_en, bram_wen, bram_we, bram_addr, bram_col, bram_din,
    input  busy
  );
endinterface

// File: rtl/synapse_access_scheduler.sv
// Shares the single synapse weight BRAM port between table load, spike-driven reads and
// buffered STDP byte write-backs, with read-after-write protection and bounded write starvation.
module synapse_access_scheduler #(
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  synapse_access_scheduler_if.slave bus
);
  localparam int COL_BITS = $clog2(NUM_COL);
  localparam int SYN_BITS = ADDR_WIDTH + COL_BITS;
  localparam int WORD_W   = NUM_COL * COL_WIDTH;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int STV_BITS = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_cnt_q, load_cnt_d;
  logic                  load_done_q, load_done_d;
  logic [SYN_BITS-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [SYN_BITS-1:0]   fifo_addr_d [FIFO_DEPTH];
  logic [COL_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [COL_WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic [STV_BITS-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  bram_en_q, bram_en_d;
  logic                  bram_wen_q, bram_wen_d;
  logic [NUM_COL-1:0]    bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [COL_BITS-1:0]   bram_col_q, bram_col_d;
  logic [WORD_W-1:0]     bram_din_q, bram_din_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  busy_q, busy_d;

  logic                  fifo_empty;
  logic                  can_push;
  logic                  push;
  logic                  pop;
  logic                  hazard;
  logic                  gnt;
  logic [SYN_BITS-1:0]   head_addr;
  logic [COL_WIDTH-1:0]  head_data;

  assign fifo_empty = (count_q == '0);
  assign can_push   = (state_q == RUN) && (count_q != CNT_BITS'(FIFO_DEPTH));
  assign push       = bus.wr_valid && can_push;
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // A read may not overtake a buffered write to the same synapse; entries pushed this cycle are not compared.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld_q[i] && (fifo_addr_q[i] == bus.rd_addr)) hazard = 1'b1;
    end
    hazard = hazard && bus.rd_req && (state_q == RUN);
    gnt    = (state_q == RUN) && bus.rd_req && !hazard &&
             (starve_cnt_q < STV_BITS'(STARVE_LIMIT));
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    load_done_d  = load_done_q;
    fifo_addr_d  = fifo_addr_q;
    fifo_data_d  = fifo_data_q;
    fifo_vld_d   = fifo_vld_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    starve_cnt_d = starve_cnt_q;
    bram_en_d    = 1'b0;
    bram_wen_d   = 1'b0;
    bram_we_d    = '0;
    bram_addr_d  = '0;
    bram_col_d   = '0;
    bram_din_d   = '0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d     = LOAD;
          load_cnt_d  = '0;
          load_done_d = 1'b0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          bram_en_d   = 1'b1;
          bram_wen_d  = 1'b1;
          bram_we_d   = '1;
          bram_addr_d = load_cnt_q;
          bram_din_d  = bus.load_data;
          load_cnt_d  = load_cnt_q + ADDR_WIDTH'(1);
          if (load_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            load_done_d = 1'b1;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (hazard) begin
          pop = 1'b1;
        end else if (gnt) begin
          bram_en_d   = 1'b1;
          bram_addr_d = bus.rd_addr[SYN_BITS-1:COL_BITS];
          bram_col_d  = bus.rd_addr[COL_BITS-1:0];
          if (!fifo_empty) starve_cnt_d = starve_cnt_q + STV_BITS'(1);
        end else if (!fifo_empty) begin
          pop          = 1'b1;
          starve_cnt_d = '0;
        end else if (bus.load_start && !bus.rd_req) begin
          state_d     = LOAD;
          load_cnt_d  = '0;
          load_done_d = 1'b0;
        end
        if (fifo_empty) starve_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Byte write-back: one-hot lane enable, data replicated so any lane sees it.
    if (pop) begin
      bram_en_d            = 1'b1;
      bram_wen_d           = 1'b1;
      bram_we_d            = NUM_COL'(1) << head_addr[COL_BITS-1:0];
      bram_addr_d          = head_addr[SYN_BITS-1:COL_BITS];
      bram_din_d           = {NUM_COL{head_data}};
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PTR_BITS'(1);
    end
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.wr_addr;
      fifo_data_d[wr_ptr_q] = bus.wr_data;
      fifo_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d              = wr_ptr_q + PTR_BITS'(1);
    end
    count_d = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

    rd_valid_d = bram_en_q && !bram_wen_q;
    busy_d     = (state_d != RUN) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      load_done_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_vld_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      bram_en_q    <= 1'b0;
      bram_wen_q   <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_col_q   <= '0;
      bram_din_q   <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      load_done_q  <= load_done_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_vld_q   <= fifo_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      bram_en_q    <= bram_en_d;
      bram_wen_q   <= bram_wen_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_col_q   <= bram_col_d;
      bram_din_q   <= bram_din_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = load_done_q;
  assign bus.rd_gnt     = gnt;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.bram_dout : '0;
  assign bus.wr_ready   = can_push;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_wen   = bram_wen_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_col   = bram_col_q;
  assign bus.bram_din   = bram_din_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_synapse_access_scheduler.sv
// Directed plus randomized bench for synapse_access_scheduler with a BRAM model and a
// synapse-level weight table predicting every read result.
module tb_synapse_access_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synapse_access_scheduler_if bif ();
  synapse_access_scheduler dut (.clk(clk), .rst(rst), .bus(bif));

  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (bif.bram_en) begin
      if (bif.bram_wen) begin
        for (int l = 0; l < 4; l++)
          if (bif.bram_we[l]) mem[bif.bram_addr][l*8 +: 8] <= bif.bram_din[l*8 +: 8];
      end else begin
        bif.bram_dout <= mem[bif.bram_addr][bif.bram_col*8 +: 8];
      end
    end
  end

  typedef struct { int due; logic [7:0] val; } exp_t;
  exp_t       sb_q [$];
  logic [7:0] ref_w [128];
  int         cyc, n_checks, n_errors;
  logic       obs_gnt, obs_push, obs_load, obs_wrrdy, obs_done;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [6:0] ra, input logic wv,
                               input logic [6:0] wa, input logic [7:0] wd);
    bif.rd_req = rq; bif.rd_addr = ra;
    bif.wr_valid = wv; bif.wr_addr = wa; bif.wr_data = wd;
  endtask

  // One clock: observe at the falling edge, then return just after the next rising edge.
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      checkOutput("rd_valid", 32'(bif.rd_valid), 32'd1);
      checkOutput("rd_data", 32'(bif.rd_data), 32'(sb_q[0].val));
      void'(sb_q.pop_front());
    end else begin
      checkOutput("rd_valid_idle", 32'(bif.rd_valid), 32'd0);
    end
    obs_gnt   = bif.rd_gnt;
    obs_wrrdy = bif.wr_ready;
    obs_done  = bif.load_done;
    obs_push  = bif.wr_valid && bif.wr_ready;
    obs_load  = bif.load_valid && bif.load_ready;
    if (obs_gnt) sb_q.push_back('{cyc + 2, ref_w[bif.rd_addr]});
    if (obs_push) ref_w[bif.wr_addr] = bif.wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 7'd0, 1'b0, 7'd0, 8'd0);
    repeat (n) stepCycle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_load_ready"}, 32'(bif.load_ready), 0);
    checkOutput({tag, "_load_done"}, 32'(bif.load_done), 0);
    checkOutput({tag, "_rd_gnt"}, 32'(bif.rd_gnt), 0);
    checkOutput({tag, "_rd_valid"}, 32'(bif.rd_valid), 0);
    checkOutput({tag, "_wr_ready"}, 32'(bif.wr_ready), 0);
    checkOutput({tag, "_bram_en"}, 32'(bif.bram_en), 0);
    checkOutput({tag, "_bram_cmd"}, {bif.bram_wen, bif.bram_we, bif.bram_addr, bif.bram_col}, 0);
    checkOutput({tag, "_bram_din"}, bif.bram_din, 0);
    checkOutput({tag, "_busy"}, 32'(bif.busy), 0);
  endtask

  task automatic loadTable(input int words, input bit jitter);
    int k, guard;
    logic [31:0] d;
    bif.load_start = 1'b1;
    stepCycle();
    bif.load_start = 1'b0;
    checkOutput("load_ready", 32'(bif.load_ready), 1);
    k = 0; guard = 0;
    while (k < words && guard < 400) begin
      d = 32'h0302_0100 + 32'h0404_0404 * k;
      bif.load_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.load_data  = d;
      stepCycle();
      guard++;
      if (obs_load) begin
        for (int l = 0; l < 4; l++) ref_w[7'(k * 4 + l)] = d[l*8 +: 8];
        if (k == 0 || k == 31) begin
          checkOutput("load_cmd_en", {31'd0, bif.bram_en}, 1);
          checkOutput("load_cmd", {bif.bram_wen, bif.bram_we, bif.bram_addr}, {22'd0, 1'b1, 4'hF, 5'(k)});
          checkOutput("load_cmd_din", bif.bram_din, d);
        end
        if (k == 31) begin
          checkOutput("load_done_pre", 32'(obs_done), 0);
          checkOutput("load_done_post", 32'(bif.load_done), 1);
        end
        k++;
      end
    end
    bif.load_valid = 1'b0;
    checkOutput("load_words", k, words);
  endtask

  task automatic doRead(input logic [6:0] a);
    int w;
    w = 0;
    bif.rd_req = 1'b1; bif.rd_addr = a;
    do begin stepCycle(); w++; end while (!obs_gnt && w < 50);
    checkOutput("rd_gnt_wait", 32'(obs_gnt), 1);
    bif.rd_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seg [4];
    int run, nseg, pushes, a, guard, rd_wait;
    cyc = 0; n_checks = 0; n_errors = 0;
    for (int i = 0; i < 128; i++) ref_w[i] = 8'h00;
    rst = 1'b1;
    bif.load_start = 1'b0; bif.load_valid = 1'b0; bif.load_data = '0;
    bif.bram_dout = '0;
    applyStimulus(1'b0, 7'd0, 1'b0, 7'd0, 8'd0);
    idle(2);
    checkAllZero("reset");
    rst = 1'b0;
    $display("[TB] reset released, IDLE checks");
    applyStimulus(1'b1, 7'd3, 1'b1, 7'd3, 8'h11);
    stepCycle();
    checkOutput("idle_rd_gnt", 32'(obs_gnt), 0);
    checkOutput("idle_wr_ready", 32'(obs_wrrdy), 0);
    checkOutput("idle_busy", 32'(bif.busy), 1);
    idle(1);

    $display("[TB] reset in the middle of a load");
    loadTable(17, 1'b0);
    rst = 1'b1;
    #1;
    checkAllZero("mid_load_reset");
    sb_q.delete();
    stepCycle();
    rst = 1'b0;
    idle(1);
    loadTable(32, 1'b1);
    stepCycle();
    checkOutput("run_load_ready", 32'(bif.load_ready), 0);
    checkOutput("run_wr_ready", 32'(obs_wrrdy), 1);

    $display("[TB] directed reads");
    applyStimulus(1'b1, 7'd10, 1'b0, 7'd0, 8'd0);
    stepCycle();
    checkOutput("rd10_gnt", 32'(obs_gnt), 1);
    bif.rd_req = 1'b0;
    checkOutput("rd10_cmd", {bif.bram_en, bif.bram_wen, bif.bram_addr, bif.bram_col}, {25'd0, 2'b10, 5'd2, 2'd2});
    idle(3);
    doRead(7'h25);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 7'(i), 1'b0, 7'd0, 8'd0);
      stepCycle();
      checkOutput("b2b_gnt", 32'(obs_gnt), 1);
    end
    idle(4);

    $display("[TB] read-after-write hazard");
    applyStimulus(1'b0, 7'd0, 1'b1, 7'd10, 8'hAA);
    stepCycle();
    applyStimulus(1'b1, 7'd10, 1'b0, 7'd0, 8'd0);
    stepCycle();
    checkOutput("hazard_no_gnt", 32'(obs_gnt), 0);
    checkOutput("hazard_wr_cmd", {bif.bram_en, bif.bram_wen, bif.bram_we, bif.bram_addr}, {21'd0, 2'b11, 4'b0100, 5'd2});
    checkOutput("hazard_wr_din", bif.bram_din, 32'hAAAA_AAAA);
    stepCycle();
    checkOutput("hazard_gnt_after", 32'(obs_gnt), 1);
    bif.rd_req = 1'b0;
    doRead(7'd8); doRead(7'd9); doRead(7'd11);
    idle(3);

    $display("[TB] write starvation bound");
    run = 0; nseg = 0; pushes = 0; a = 0; guard = 0;
    for (int i = 0; i < 4; i++) seg[i] = 0;
    while (nseg < 4 && guard < 80) begin
      applyStimulus(1'b1, 7'(a), pushes < 4, 7'(100 + pushes), 8'($urandom));
      stepCycle();
      guard++;
      if (guard == 5) checkOutput("wr_ready_full", 32'(obs_wrrdy), 0);
      if (obs_push) pushes++;
      if (obs_gnt) begin run++; a++; end
      else begin seg[nseg] = run; nseg++; run = 0; end
    end
    idle(3);
    checkOutput("starve_pushes", pushes, 4);
    checkOutput("starve_seg0", seg[0], 5);
    for (int i = 1; i < 4; i++) checkOutput("starve_seg", seg[i], 4);
    for (int i = 100; i < 104; i++) doRead(7'(i));
    idle(3);

    $display("[TB] randomized traffic");
    rd_wait = 0;
    bif.rd_req = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!bif.rd_req && $urandom_range(0, 1) == 1) begin
        bif.rd_req = 1'b1; bif.rd_addr = 7'($urandom_range(0, 127)); rd_wait = 0;
      end
      bif.wr_valid = ($urandom_range(0, 2) == 0);
      bif.wr_addr  = 7'($urandom_range(0, 127));
      bif.wr_data  = 8'($urandom);
      stepCycle();
      if (bif.rd_req) begin
        if (obs_gnt) bif.rd_req = 1'b0;
        else begin
          rd_wait++;
          if (rd_wait > 40) begin
            checkOutput("rand_rd_wait", 32'(obs_gnt), 1);
            bif.rd_req = 1'b0;
          end
        end
      end
    end
    idle(10);
    checkOutput("drained_busy", 32'(bif.busy), 0);
    for (int i = 0; i < 128; i++) doRead(7'(i));
    idle(3);

    $display("[TB] load_start while writes pending");
    applyStimulus(1'b0, 7'd0, 1'b1, 7'd5, 8'h55);
    stepCycle();
    applyStimulus(1'b0, 7'd0, 1'b0, 7'd0, 8'd0);
    bif.load_start = 1'b1;
    stepCycle();
    bif.load_start = 1'b0;
    checkOutput("ignored_load_ready", 32'(bif.load_ready), 0);
    stepCycle();
    bif.load_start = 1'b1;
    stepCycle();
    bif.load_start = 1'b0;
    checkOutput("reload_ready", 32'(bif.load_ready), 1);
    checkOutput("reload_done_clr", 32'(bif.load_done), 0);
    checkOutput("reload_busy", 32'(bif.busy), 1);
    applyStimulus(1'b1, 7'd0, 1'b0, 7'd0, 8'd0);
    stepCycle();
    checkOutput("load_no_gnt0", 32'(obs_gnt), 0);
    stepCycle();
    checkOutput("load_no_gnt1", 32'(obs_gnt), 0);
    bif.rd_req = 1'b0;
    loadTable(32, 1'b0);
    doRead(7'd5);
    doRead(7'h25);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
